// File: rtl/multi_dataflow_package.sv
// Shared types for the multi-dataflow engine: kernel adapter ctrl/flags bundles,
// engine controller state encoding and job status codes.
package multi_dataflow_package;

    typedef struct packed {
        logic start;
    } ctrl_kernel_adapter_t;

    typedef struct packed {
        logic done;
        logic ready;
        logic idle;
    } flags_kernel_adapter_t;

    typedef enum logic [2:0] {
        ENG_IDLE,
        ENG_STREAM_REQ,
        ENG_KSTART,
        ENG_COMPUTE,
        ENG_DRAIN,
        ENG_FINISH
    } engine_ctrl_state_t;

    typedef enum logic [1:0] {
        JOB_OK      = 2'b00,
        JOB_TIMEOUT = 2'b01,
        JOB_ABORT   = 2'b10,
        JOB_OVERRUN = 2'b11
    } job_status_t;

endpackage

// File: rtl/multi_dataflow_engine_watchdog.sv
// Inactivity watchdog: restarts on load_i, advances while en_i, flags expiry on the
// TIMEOUT-th enabled cycle. TIMEOUT=0 removes the counter entirely.
module multi_dataflow_engine_watchdog #(
    parameter int unsigned TO_W    = 16,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    if (TIMEOUT == 0) begin : g_bypass
        logic unused_wd;
        assign unused_wd = ^{clk_i, rst_i, load_i, en_i};
        assign expire_o  = 1'b0;
    end else begin : g_count
        localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);
        logic [TO_W-1:0] cnt_q;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                cnt_q <= '0;
            end else if (load_i) begin
                cnt_q <= '0;
            end else if (en_i && (cnt_q != LAST)) begin
                cnt_q <= cnt_q + TO_W'(1);
            end
        end

        assign expire_o = en_i && (cnt_q == LAST);
    end

endmodule

// File: rtl/multi_dataflow_engine_ctrl.sv
// Engine-side job controller: triggers streamers, pulses kernel start, counts done
// flags, waits for kernel idle and reports job status with a watchdog and abort.
module multi_dataflow_engine_ctrl
    import multi_dataflow_package::*;
#(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TO_W    = 16,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  job_start_i,
    input  logic [CNT_W-1:0]      job_len_i,
    input  logic                  job_abort_i,
    output ctrl_kernel_adapter_t  ctrl_o,
    input  flags_kernel_adapter_t flags_i,
    output logic                  in_stream_req_o,
    output logic                  out_stream_req_o,
    output logic                  job_busy_o,
    output logic                  job_done_o,
    output logic [1:0]            job_status_o,
    output logic [CNT_W-1:0]      cnt_out_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    engine_ctrl_state_t state_q, state_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    job_status_t        status_q, status_d;
    logic               zero_done_q, zero_done_d;
    logic               wd_load, wd_en, wd_expire;
    logic               unused_ready;

    assign unused_ready = flags_i.ready;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ENG_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            status_q    <= JOB_OK;
            zero_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            status_q    <= status_d;
            zero_done_q <= zero_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        status_d    = status_q;
        zero_done_d = 1'b0;
        wd_load     = 1'b0;
        unique case (state_q)
            ENG_IDLE: begin
                if (job_start_i) begin
                    cnt_d    = '0;
                    status_d = JOB_OK;
                    if (job_len_i != '0) begin
                        len_d   = job_len_i;
                        state_d = ENG_STREAM_REQ;
                    end else begin
                        zero_done_d = 1'b1;
                    end
                end
            end
            ENG_STREAM_REQ: begin
                if (job_abort_i) begin
                    status_d = JOB_ABORT;
                    state_d  = ENG_FINISH;
                end else begin
                    state_d = ENG_KSTART;
                end
            end
            ENG_KSTART: begin
                if (job_abort_i) begin
                    status_d = JOB_ABORT;
                    state_d  = ENG_FINISH;
                end else begin
                    wd_load = 1'b1;
                    state_d = ENG_COMPUTE;
                end
            end
            ENG_COMPUTE: begin
                if (job_abort_i) begin
                    status_d = JOB_ABORT;
                    state_d  = ENG_FINISH;
                end else if (flags_i.done) begin
                    cnt_d   = cnt_q + CNT_ONE;
                    wd_load = 1'b1;
                    if (cnt_q == len_q - CNT_ONE) begin
                        state_d = ENG_DRAIN;
                    end
                end else if (wd_expire) begin
                    status_d = JOB_TIMEOUT;
                    state_d  = ENG_FINISH;
                end
            end
            ENG_DRAIN: begin
                if (job_abort_i) begin
                    status_d = JOB_ABORT;
                    state_d  = ENG_FINISH;
                end else begin
                    // Late done means the kernel produced more than the job asked for.
                    if (flags_i.done) begin
                        cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;
                        status_d = JOB_OVERRUN;
                        wd_load  = 1'b1;
                    end
                    if (flags_i.idle) begin
                        state_d = ENG_FINISH;
                    end else if (!flags_i.done && wd_expire) begin
                        status_d = JOB_TIMEOUT;
                        state_d  = ENG_FINISH;
                    end
                end
            end
            ENG_FINISH: begin
                state_d = ENG_IDLE;
            end
            default: begin
                state_d = ENG_IDLE;
            end
        endcase
    end

    assign wd_en = ((state_q == ENG_COMPUTE) || (state_q == ENG_DRAIN)) && !flags_i.done;

    multi_dataflow_engine_watchdog #(
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) i_watchdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (wd_load),
        .en_i     (wd_en),
        .expire_o (wd_expire)
    );

    assign ctrl_o.start     = (state_q == ENG_KSTART);
    assign in_stream_req_o  = (state_q == ENG_STREAM_REQ);
    assign out_stream_req_o = (state_q == ENG_STREAM_REQ);
    assign job_busy_o       = (state_q != ENG_IDLE);
    assign job_done_o       = (state_q == ENG_FINISH) || zero_done_q;
    assign job_status_o     = status_q;
    assign cnt_out_o        = cnt_q;

endmodule

// File: tb/tb_multi_dataflow_engine_ctrl.sv
// Bench for the engine controller: scripted and randomized jobs scored against an
// event-level model of job outcome (end cycle, output count, status).
module tb_multi_dataflow_engine_ctrl;
    import multi_dataflow_package::*;

    localparam int CNT_W   = 16;
    localparam int TO_W    = 16;
    localparam int TIMEOUT = 16;
    localparam int MAXC    = 128;

    logic                  clk_i = 1'b0;
    logic                  rst_i;
    logic                  job_start_i;
    logic [CNT_W-1:0]      job_len_i;
    logic                  job_abort_i;
    ctrl_kernel_adapter_t  ctrl_o;
    flags_kernel_adapter_t flags_i;
    logic                  in_stream_req_o;
    logic                  out_stream_req_o;
    logic                  job_busy_o;
    logic                  job_done_o;
    logic [1:0]            job_status_o;
    logic [CNT_W-1:0]      cnt_out_o;

    multi_dataflow_engine_ctrl #(
        .CNT_W   (CNT_W),
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .job_start_i      (job_start_i),
        .job_len_i        (job_len_i),
        .job_abort_i      (job_abort_i),
        .ctrl_o           (ctrl_o),
        .flags_i          (flags_i),
        .in_stream_req_o  (in_stream_req_o),
        .out_stream_req_o (out_stream_req_o),
        .job_busy_o       (job_busy_o),
        .job_done_o       (job_done_o),
        .job_status_o     (job_status_o),
        .cnt_out_o        (cnt_out_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    // Per-cycle stimulus schedule; cycle 0 is the cycle job_start_i is driven.
    bit done_s [MAXC];
    bit idle_s [MAXC];
    bit rdy_s  [MAXC];
    bit abort_s[MAXC];
    bit start_s[MAXC];
    bit rst_s  [MAXC];

    // Observations of one run.
    int sreq_n, sreq_at, pair_bad, kst_n, kst_at, done_n, done_at, busy_n;
    int cnt_at_done, st_at_done, fin_cnt, fin_st, fin_busy;

    task automatic clear_sched();
        for (int c = 0; c < MAXC; c++) begin
            done_s[c] = 0; idle_s[c] = 0; rdy_s[c] = 0;
            abort_s[c] = 0; start_s[c] = 0; rst_s[c] = 0;
        end
    endtask

    // Outcome from event times: the job ends on the cycle of an abort, of the
    // first idle after the len-th counted done, or TIMEOUT quiet cycles after the
    // last done (or after the kernel start). Dones count from cycle 3 onward.
    function automatic void model(input int len, output int e_end, output int e_cnt,
                                  output int e_st);
        int  cnt  = 0;
        int  last = 2;
        bit  over = 0;
        bit  drain;
        e_end = 1000; e_cnt = -1; e_st = -1;
        for (int c = 1; c < MAXC; c++) begin
            if (abort_s[c]) begin
                e_end = c; e_cnt = cnt; e_st = 2; return;
            end
            if (c < 3) continue;
            drain = (cnt >= len);
            if (done_s[c]) begin
                if (drain) over = 1;
                if (cnt < (1 << CNT_W) - 1) cnt++;
                last = c;
            end
            if (drain && idle_s[c]) begin
                e_end = c; e_cnt = cnt; e_st = over ? 3 : 0; return;
            end
            if (!done_s[c] && c == last + TIMEOUT) begin
                e_end = c; e_cnt = cnt; e_st = 1; return;
            end
        end
    endfunction

    task automatic run_job(input int len, input int ncyc);
        sreq_n = 0; sreq_at = -1; pair_bad = 0; kst_n = 0; kst_at = -1;
        done_n = 0; done_at = -1; busy_n = 0; cnt_at_done = -1; st_at_done = -1;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk_i);
            if (in_stream_req_o) begin
                sreq_n++;
                if (sreq_at < 0) sreq_at = k;
            end
            if (out_stream_req_o !== in_stream_req_o) pair_bad++;
            if (ctrl_o.start) begin
                kst_n++;
                if (kst_at < 0) kst_at = k;
            end
            if (job_done_o) begin
                done_n++;
                if (done_at < 0) begin
                    done_at = k; cnt_at_done = int'(cnt_out_o); st_at_done = int'(job_status_o);
                end
            end
            if (job_busy_o) busy_n++;
            job_start_i   = (k == 0) || start_s[k];
            job_len_i     = (k == 0) ? CNT_W'(len) : CNT_W'($urandom);
            job_abort_i   = abort_s[k];
            flags_i.done  = done_s[k];
            flags_i.ready = rdy_s[k];
            flags_i.idle  = idle_s[k];
            rst_i         = rst_s[k];
        end
        @(negedge clk_i);
        job_start_i = 0; job_abort_i = 0; flags_i = '0; rst_i = 0;
        fin_cnt = int'(cnt_out_o); fin_st = int'(job_status_o); fin_busy = int'(job_busy_o);
    endtask

    task automatic test_reset();
        rst_i = 1; job_start_i = 0; job_len_i = '0; job_abort_i = 0; flags_i = '0;
        repeat (3) @(negedge clk_i);
        n_cmp++; if (job_busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", job_busy_o); end
        n_cmp++; if (job_done_o !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", job_done_o); end
        n_cmp++; if (job_status_o !== 2'b00) begin n_bad++; $display("FAIL reset_status: got %b expected 00", job_status_o); end
        n_cmp++; if (cnt_out_o !== '0) begin n_bad++; $display("FAIL reset_cnt: got %0d expected 0", cnt_out_o); end
        n_cmp++; if ({ctrl_o.start, in_stream_req_o, out_stream_req_o} !== 3'b000) begin
            n_bad++; $display("FAIL reset_pulses: got %b expected 000", {ctrl_o.start, in_stream_req_o, out_stream_req_o});
        end
        rst_i = 0;
        @(negedge clk_i);
    endtask

    task automatic test_basic();
        int e_end, e_cnt, e_st;
        clear_sched();
        done_s[3] = 1; done_s[6] = 1; done_s[9] = 1; done_s[12] = 1; idle_s[13] = 1;
        model(4, e_end, e_cnt, e_st);
        run_job(4, 24);
        n_cmp++; if (sreq_n != 1 || sreq_at != 1) begin n_bad++; $display("FAIL basic_sreq: got n=%0d at=%0d expected n=1 at=1", sreq_n, sreq_at); end
        n_cmp++; if (pair_bad != 0) begin n_bad++; $display("FAIL basic_sreq_pair: got %0d differing cycles expected 0", pair_bad); end
        n_cmp++; if (kst_n != 1 || kst_at != 2) begin n_bad++; $display("FAIL basic_start: got n=%0d at=%0d expected n=1 at=2", kst_n, kst_at); end
        n_cmp++; if (done_n != 1 || done_at != 14 || done_at != e_end + 1) begin
            n_bad++; $display("FAIL basic_done: got n=%0d at=%0d expected n=1 at=14", done_n, done_at);
        end
        n_cmp++; if (cnt_at_done != 4 || st_at_done != 0 || e_st != 0) begin
            n_bad++; $display("FAIL basic_result: got cnt=%0d st=%0d expected cnt=4 st=0", cnt_at_done, st_at_done);
        end
        n_cmp++; if (fin_cnt != e_cnt || fin_st != e_st || fin_busy != 0) begin
            n_bad++; $display("FAIL basic_hold: got cnt=%0d st=%0d busy=%0d expected cnt=%0d st=%0d busy=0", fin_cnt, fin_st, fin_busy, e_cnt, e_st);
        end
    endtask

    task automatic test_timeout();
        int e_end, e_cnt, e_st;
        clear_sched();
        done_s[4] = 1; done_s[7] = 1;
        model(3, e_end, e_cnt, e_st);
        run_job(3, 32);
        n_cmp++; if (done_n != 1 || done_at != 7 + TIMEOUT + 1) begin
            n_bad++; $display("FAIL timeout_done: got n=%0d at=%0d expected n=1 at=%0d", done_n, done_at, 7 + TIMEOUT + 1);
        end
        n_cmp++; if (cnt_at_done != 2 || st_at_done != 1 || e_st != 1 || e_cnt != 2) begin
            n_bad++; $display("FAIL timeout_result: got cnt=%0d st=%0d expected cnt=2 st=1", cnt_at_done, st_at_done);
        end
    endtask

    task automatic test_abort();
        clear_sched();
        done_s[3] = 1; done_s[5] = 1; done_s[7] = 1; abort_s[7] = 1; idle_s[9] = 1;
        run_job(5, 20);
        n_cmp++; if (done_n != 1 || done_at != 8) begin n_bad++; $display("FAIL abort_done: got n=%0d at=%0d expected n=1 at=8", done_n, done_at); end
        n_cmp++; if (cnt_at_done != 2 || st_at_done != 2) begin
            n_bad++; $display("FAIL abort_result: got cnt=%0d st=%0d expected cnt=2 st=2", cnt_at_done, st_at_done);
        end
    endtask

    task automatic test_overrun();
        clear_sched();
        done_s[3] = 1; done_s[5] = 1; done_s[7] = 1; idle_s[9] = 1;
        run_job(2, 16);
        n_cmp++; if (done_n != 1 || done_at != 10) begin n_bad++; $display("FAIL overrun_done: got n=%0d at=%0d expected n=1 at=10", done_n, done_at); end
        n_cmp++; if (cnt_at_done != 3 || st_at_done != 3) begin
            n_bad++; $display("FAIL overrun_result: got cnt=%0d st=%0d expected cnt=3 st=3", cnt_at_done, st_at_done);
        end
    endtask

    task automatic test_zero_len();
        clear_sched();
        done_s[1] = 1; done_s[2] = 1; done_s[3] = 1; idle_s[4] = 1;
        run_job(0, 8);
        n_cmp++; if (done_n != 1 || done_at != 1) begin n_bad++; $display("FAIL zero_done: got n=%0d at=%0d expected n=1 at=1", done_n, done_at); end
        n_cmp++; if (kst_n != 0 || sreq_n != 0 || busy_n != 0) begin
            n_bad++; $display("FAIL zero_quiet: got start=%0d sreq=%0d busy=%0d expected all 0", kst_n, sreq_n, busy_n);
        end
        n_cmp++; if (fin_cnt != 0 || fin_st != 0) begin n_bad++; $display("FAIL zero_result: got cnt=%0d st=%0d expected cnt=0 st=0", fin_cnt, fin_st); end
    endtask

    task automatic test_restart_ignored();
        clear_sched();
        start_s[5] = 1; start_s[8] = 1;
        done_s[3] = 1; done_s[5] = 1; done_s[7] = 1; done_s[9] = 1; idle_s[10] = 1;
        run_job(4, 20);
        n_cmp++; if (sreq_n != 1 || kst_n != 1) begin n_bad++; $display("FAIL restart_pulses: got sreq=%0d start=%0d expected 1 1", sreq_n, kst_n); end
        n_cmp++; if (done_n != 1 || done_at != 11 || cnt_at_done != 4 || st_at_done != 0) begin
            n_bad++; $display("FAIL restart_result: got n=%0d at=%0d cnt=%0d st=%0d expected n=1 at=11 cnt=4 st=0", done_n, done_at, cnt_at_done, st_at_done);
        end
    endtask

    task automatic test_reset_mid();
        clear_sched();
        done_s[3] = 1; done_s[5] = 1; rst_s[6] = 1; done_s[8] = 1; done_s[9] = 1; idle_s[10] = 1;
        run_job(4, 16);
        n_cmp++; if (sreq_n != 1 || done_n != 0) begin n_bad++; $display("FAIL rstmid_done: got sreq=%0d done=%0d expected sreq=1 done=0", sreq_n, done_n); end
        n_cmp++; if (fin_cnt != 0 || fin_st != 0 || fin_busy != 0) begin
            n_bad++; $display("FAIL rstmid_state: got cnt=%0d st=%0d busy=%0d expected 0 0 0", fin_cnt, fin_st, fin_busy);
        end
    endtask

    task automatic test_random();
        int len, e_end, e_cnt, e_st;
        for (int j = 0; j < 20; j++) begin
            clear_sched();
            len = int'($urandom_range(1, 6));
            for (int c = 0; c < 100; c++) begin
                if (c < 60) done_s[c] = ($urandom_range(0, 2) == 0);
                idle_s[c] = ($urandom_range(0, 2) == 0);
                rdy_s[c]  = $urandom_range(0, 1) == 1;
            end
            if ($urandom_range(0, 3) == 0) abort_s[$urandom_range(1, 40)] = 1;
            model(len, e_end, e_cnt, e_st);
            run_job(len, 100);
            n_cmp++; if (done_n != 1 || done_at != e_end + 1) begin
                n_bad++; $display("FAIL rand%0d_done: got n=%0d at=%0d expected n=1 at=%0d", j, done_n, done_at, e_end + 1);
            end
            n_cmp++; if (cnt_at_done != e_cnt || st_at_done != e_st) begin
                n_bad++; $display("FAIL rand%0d_result: got cnt=%0d st=%0d expected cnt=%0d st=%0d", j, cnt_at_done, st_at_done, e_cnt, e_st);
            end
            n_cmp++; if (sreq_n != 1 || kst_n != ((e_end >= 2) ? 1 : 0)) begin
                n_bad++; $display("FAIL rand%0d_pulses: got sreq=%0d start=%0d expected sreq=1 start=%0d", j, sreq_n, kst_n, (e_end >= 2) ? 1 : 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_abort();
        test_overrun();
        test_zero_len();
        test_restart_ignored();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL sim_timeout: simulation did not complete within the time limit");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/multi_dataflow_engine_ctrl.md
Name: multi_dataflow_engine_ctrl

Overview:
- Engine-side controller on the opposite end of the kernel adapter's ctrl/flags interface.
- Accepts a job (output count) from the HWPE control slave and triggers the input/output streamers.
- Issues the kernel start pulse on ctrl_o, then consumes flags_i (done/ready/idle) to count outputs, detect completion, enforce a watchdog and report job status.
- Sits in the HWPE engine between the register file/ctrl slave and the kernel adapter.

Parameters:
- CNT_W, 16, width of job length and output counter.
- TO_W, 16, width of watchdog counter.
- TIMEOUT, 4096, idle cycles allowed between done pulses (and in drain); 0 disables the watchdog.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset; synchronous, active-high.
- job_start_i  input  1  job request pulse.
- job_len_i  input  CNT_W  outputs expected; sampled with job_start_i.
- job_abort_i  input  1  abort request.
- ctrl_o  output  ctrl_kernel_adapter_t  start is a one-cycle pulse.
- flags_i  input  flags_kernel_adapter_t  done, ready, idle.
- in_stream_req_o  output  1  input streamer trigger pulse.
- out_stream_req_o  output  1  output streamer trigger pulse.
- job_busy_o  output  1  high outside IDLE.
- job_done_o  output  1  one-cycle completion pulse.
- job_status_o  output  2  job result: 00 ok, 01 timeout, 10 abort, 11 overrun.
- cnt_out_o  output  CNT_W  outputs counted in the current or last job.

Behaviour:
- Reset (rst_i high at a clk_i edge): state IDLE; all pulses 0; job_busy_o=0; job_status_o=00; cnt_out_o=0; latched length 0; watchdog 0. Reset mid-job aborts silently: no job_done_o.
- FSM states: IDLE, STREAM_REQ, KSTART, COMPUTE, DRAIN, FINISH. All outputs are registered or decoded from state only.
- IDLE:
  - job_start_i with job_len_i!=0: latch len; clear cnt_out and status; go to STREAM_REQ.
  - job_start_i with job_len_i==0: job_done_o pulses the next cycle, status=00, stay IDLE, no start or stream request.
- STREAM_REQ: in_stream_req_o=out_stream_req_o=1 for exactly one cycle; go to KSTART.
- KSTART: ctrl_o.start=1 for exactly one cycle; go to COMPUTE. The kernel adapter clears its counters on this start.
- COMPUTE:
  - Each cycle with flags_i.done=1 increments cnt_out and reloads the watchdog.
  - When done arrives with cnt_out==len-1: cnt_out becomes len and the FSM goes to DRAIN.
  - flags_i.ready is observed only; no restart is issued.
- DRAIN:
  - Wait for flags_i.idle=1, then go to FINISH with status 00.
  - A done in DRAIN increments cnt_out (saturating at all-ones) and sets status 11. The FSM still waits for idle.
- Watchdog (TIMEOUT!=0):
  - Counts cycles in COMPUTE/DRAIN with no done and no idle exit.
  - On reaching TIMEOUT, go to FINISH with status 01.
- Abort: job_abort_i in STREAM_REQ, KSTART, COMPUTE or DRAIN goes to FINISH with status 10. Abort has priority over a simultaneous done, idle or timeout. Abort in IDLE or FINISH is ignored.
- FINISH: job_done_o=1 for one cycle; go to IDLE. job_status_o and cnt_out_o hold until the next accepted job_start_i.
- job_start_i outside IDLE is ignored and not queued.
- Done pulses in IDLE, STREAM_REQ, KSTART or FINISH are ignored.
- Latency:
  - job_start_i to stream requests: 1 cycle.
  - job_start_i to ctrl_o.start: 2 cycles.
  - Final done to job_done_o: at least 2 cycles (DRAIN needs idle).
- Counter compare uses the latched length. Equality checks only, no wrap: len is at most 2^CNT_W-1.

Decomposition:
- multi_dataflow_package: add the state enum engine_ctrl_state_t and the job_status_t encoding constants.
- ctrl_kernel_adapter_t and flags_kernel_adapter_t are reused unchanged.
- One sub-module: multi_dataflow_engine_watchdog (load/enable/expire counter, TIMEOUT=0 bypass).

Test Plan:
- len=4, four done pulses spaced 3 cycles, idle 1 cycle after the last -> one stream-req pulse, one start pulse 2 cycles after job_start_i, cnt_out_o=4, status 00, job_done_o 2 cycles after the last done.
- len=0 -> job_done_o pulse next cycle, status 00, no ctrl_o.start, busy never asserted.
- len=3, only 2 dones, TIMEOUT=16 -> 16 cycles after the second done: FINISH, status 01, cnt_out_o=2.
- len=5, abort asserted in the same cycle as the 3rd done -> status 10, cnt_out_o=2, single job_done_o.
- len=2, extra done in DRAIN before idle -> cnt_out_o=3, status 11.
- job_start_i during COMPUTE, and rst_i mid-COMPUTE -> second start ignored; after reset, all outputs zero, no job_done_o.
